// File: rtl/fifo_sync_if.sv
// Handshake bundle between the ADC capture path, the burst FIFO and the FT2232H writer.
// The master side drives the ADC sample and the USB TXE# status; the slave side is the buffer.
interface fifo_sync_if #(
   parameter int WIDTH     = 8,
   parameter int ADC_WIDTH = 12
);
   logic [ADC_WIDTH-1:0] adc_i;
   logic                 ft_txe_n_i;
   logic                 ft_wr_n_o;
   logic [WIDTH-1:0]     ft_data_o;
   logic [1:0]           state_o;
   logic                 full_o;
   logic                 empty_o;
   logic                 almost_full_o;
   logic                 almost_empty_o;
   logic                 overflow_o;

   modport master (
      output adc_i, ft_txe_n_i,
      input  ft_wr_n_o, ft_data_o, state_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o
   );

   modport slave (
      input  adc_i, ft_txe_n_i,
      output ft_wr_n_o, ft_data_o, state_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o
   );
endinterface

// File: rtl/fifo_sync.sv
// Capture/stream buffer: PROD fills a FWFT FIFO with one burst of byte-split ADC samples,
// CONS drains it to the FT2232H framed by 5A ... A5, then capture resumes.
module fifo_sync #(
   parameter int WIDTH     = 8,
   parameter int ADC_WIDTH = 12,
   parameter int SAMPLES   = 20480,
   parameter int DEPTH     = 40960
) (
   input  logic        clk,
   input  logic        rst,
   fifo_sync_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(SAMPLES + 1);
   localparam logic [WIDTH-1:0] START_FLAG = WIDTH'(8'h5A);
   localparam logic [WIDTH-1:0] STOP_FLAG  = WIDTH'(8'hA5);

   typedef enum logic [1:0] {
      ST_PROD = 2'b01,
      ST_CONS = 2'b10
   } state_t;

   state_t               r_state;
   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [CW-1:0]        r_count;
   logic                 r_phase;
   logic [ADC_WIDTH-1:0] r_latch;
   logic [SW-1:0]        r_sample_ctr;
   logic                 r_start_sent;
   logic                 r_overflow;
   logic                 r_full;
   logic                 r_empty;
   logic                 r_afull;
   logic                 r_aempty;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr_en;
   logic                 w_rd_en;
   logic                 w_accept;
   logic [WIDTH-1:0]     w_wr_data;
   logic [WIDTH-1:0]     w_head;
   logic [CW-1:0]        w_count_nxt;

   // Pointers wrap at DEPTH by compare, so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_full      = (r_count == CW'(DEPTH));
      w_empty     = (r_count == '0);
      w_head      = r_mem[r_rptr];
      w_wr_data   = r_phase ? WIDTH'(r_latch[ADC_WIDTH-1:WIDTH]) : bus.adc_i[WIDTH-1:0];
      w_wr_en     = (r_state == ST_PROD) && !w_full;
      w_accept    = (r_state == ST_CONS) && !bus.ft_txe_n_i;
      w_rd_en     = w_accept && r_start_sent && !w_empty;
      w_count_nxt = r_count;
      if (w_wr_en)      w_count_nxt = r_count + 1'b1;
      else if (w_rd_en) w_count_nxt = r_count - 1'b1;
   end

   always_comb begin
      bus.ft_wr_n_o = 1'b1;
      bus.ft_data_o = '0;
      if (r_state == ST_CONS) begin
         bus.ft_wr_n_o = bus.ft_txe_n_i;
         if (!r_start_sent)  bus.ft_data_o = START_FLAG;
         else if (!w_empty)  bus.ft_data_o = w_head;
         else                bus.ft_data_o = STOP_FLAG;
      end
   end

   assign bus.state_o        = r_state;
   assign bus.full_o         = r_full;
   assign bus.empty_o        = r_empty;
   assign bus.almost_full_o  = r_afull;
   assign bus.almost_empty_o = r_aempty;
   assign bus.overflow_o     = r_overflow;

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr] <= w_wr_data;
      if (r_state == ST_PROD && !r_phase) r_latch <= bus.adc_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_PROD;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_phase      <= 1'b0;
         r_sample_ctr <= '0;
         r_start_sent <= 1'b0;
         r_overflow   <= 1'b0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_afull      <= 1'b0;
         r_aempty     <= 1'b1;
      end else begin
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == CW'(DEPTH));
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= CW'(DEPTH - 1));
         r_aempty <= (w_count_nxt <= CW'(1));
         case (r_state)
            ST_PROD: begin
               if (w_full)  r_overflow <= 1'b1;
               if (w_wr_en) r_wptr     <= ptr_inc(r_wptr);
               r_phase <= !r_phase;
               if (r_phase) begin
                  r_sample_ctr <= r_sample_ctr + 1'b1;
                  if (r_sample_ctr == SW'(SAMPLES - 1)) r_state <= ST_CONS;
               end
            end
            ST_CONS: begin
               // Each accepted write advances exactly one framing step: START, a data byte, or STOP.
               if (w_accept) begin
                  if (!r_start_sent) begin
                     r_start_sent <= 1'b1;
                  end else if (w_empty) begin
                     r_state      <= ST_PROD;
                     r_start_sent <= 1'b0;
                     r_phase      <= 1'b0;
                     r_sample_ctr <= '0;
                  end else begin
                     r_rptr <= ptr_inc(r_rptr);
                  end
               end
            end
            default: r_state <= ST_PROD;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync with SAMPLES=4, DEPTH=8: a queue model checked every cycle
// plus literal wire-stream and flag expectations for each directed scenario.
module tb_fifo_sync;
   localparam int W  = 8;
   localparam int AW = 12;
   localparam int NS = 4;
   localparam int DP = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fifo_sync_if #(.WIDTH(W), .ADC_WIDTH(AW)) bus ();

   fifo_sync #(.WIDTH(W), .ADC_WIDTH(AW), .SAMPLES(NS), .DEPTH(DP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] wire_q [$];
   logic [7:0] exp_q  [$];

   // Model state: the burst as a byte queue plus where the framing stands.
   logic [7:0]  mq [$];
   bit          mvalid  = 1'b0;
   bit          m_cons  = 1'b0;
   bit          m_start = 1'b0;
   bit          m_msb   = 1'b0;
   bit          m_ovf   = 1'b0;
   logic [11:0] m_samp;
   int          m_nsamp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic build_exp(input logic [11:0] s0, input logic [11:0] inc);
      logic [11:0] s;
      s = s0;
      exp_q.delete();
      exp_q.push_back(8'h5A);
      for (int i = 0; i < NS; i++) begin
         exp_q.push_back(s[7:0]);
         exp_q.push_back({4'h0, s[11:8]});
         s = s + inc;
      end
      exp_q.push_back(8'hA5);
   endtask

   task automatic chk_wire(input string name);
      chk({name, "_len"}, 32'(wire_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < wire_q.size()) chk(name, 32'(wire_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic [7:0] e_data;
      logic       e_wr_n;
      int         n;
      forever begin
         @(negedge clk);
         if (mvalid) begin
            n      = mq.size();
            e_wr_n = 1'b1;
            e_data = 8'h00;
            if (m_cons) begin
               e_wr_n = bus.ft_txe_n_i;
               if (!m_start)   e_data = 8'h5A;
               else if (n > 0) e_data = mq[0];
               else            e_data = 8'hA5;
            end
            chk("wr_n",   32'(bus.ft_wr_n_o),      32'(e_wr_n));
            chk("data",   32'(bus.ft_data_o),      32'(e_data));
            chk("state",  32'(bus.state_o),        m_cons ? 32'd2 : 32'd1);
            chk("full",   32'(bus.full_o),         32'(n == DP));
            chk("empty",  32'(bus.empty_o),        32'(n == 0));
            chk("afull",  32'(bus.almost_full_o),  32'(n >= DP - 1));
            chk("aempty", 32'(bus.almost_empty_o), 32'(n <= 1));
            chk("ovf",    32'(bus.overflow_o),     32'(m_ovf));
            if (bus.ft_wr_n_o === 1'b0) wire_q.push_back(bus.ft_data_o);
         end
         if (rst) begin
            mq.delete();
            m_cons = 0; m_start = 0; m_msb = 0; m_ovf = 0; m_nsamp = 0;
            mvalid = 1'b1;
         end else if (mvalid) begin
            if (!m_cons) begin
               if (!m_msb) begin
                  m_samp = bus.adc_i;
                  if (mq.size() < DP) mq.push_back(m_samp[7:0]); else m_ovf = 1;
               end else begin
                  if (mq.size() < DP) mq.push_back({4'h0, m_samp[11:8]}); else m_ovf = 1;
                  m_nsamp++;
                  if (m_nsamp == NS) m_cons = 1;
               end
               m_msb = !m_msb;
            end else if (!bus.ft_txe_n_i) begin
               if (!m_start)            m_start = 1;
               else if (mq.size() > 0)  void'(mq.pop_front());
               else begin
                  m_cons = 0; m_start = 0; m_msb = 0; m_nsamp = 0;
               end
            end
         end
      end
   end

   initial begin
      int n_a5;
      bus.adc_i      = '0;
      bus.ft_txe_n_i = 1'b0;

      // Reset state
      do_reset();
      chk("rst_wr_n",  32'(bus.ft_wr_n_o),  32'd1);
      chk("rst_data",  32'(bus.ft_data_o),  32'd0);
      chk("rst_state", 32'(bus.state_o),    32'd1);
      chk("rst_empty", 32'(bus.empty_o),    32'd1);
      chk("rst_ovf",   32'(bus.overflow_o), 32'd0);

      // Constant sample, free-running USB side
      rst = 1'b1; tick(2);
      rst = 1'b0; bus.adc_i = 12'hABC; bus.ft_txe_n_i = 1'b0;
      wire_q.delete();
      tick(8);
      chk("t2_state_cons", 32'(bus.state_o), 32'd2);
      chk("t2_full",       32'(bus.full_o),  32'd1);
      tick(10);
      chk("t2_state_prod", 32'(bus.state_o), 32'd1);
      chk("t2_empty",      32'(bus.empty_o), 32'd1);
      exp_q = '{8'h5A, 8'hBC, 8'h0A, 8'hBC, 8'h0A, 8'hBC, 8'h0A, 8'hBC, 8'h0A, 8'hA5};
      chk_wire("t2_wire");

      // Incrementing sample: MSB byte belongs to the latched sample, not the current input
      rst = 1'b1; tick(2);
      rst = 1'b0; bus.adc_i = 12'h100;
      wire_q.delete();
      for (int i = 0; i < 8; i++) begin
         tick(1);
         bus.adc_i = bus.adc_i + 12'h001;
      end
      tick(10);
      exp_q = '{8'h5A, 8'h00, 8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h06, 8'h01, 8'hA5};
      chk_wire("t3_wire");

      // Five-cycle stall mid-drain
      do_reset();
      bus.adc_i = 12'h3C7; bus.ft_txe_n_i = 1'b0;
      wire_q.delete();
      tick(8);
      tick(4);
      bus.ft_txe_n_i = 1'b1;
      tick(5);
      chk("t4_stall_wr_n",  32'(bus.ft_wr_n_o),   32'd1);
      chk("t4_stall_bytes", 32'(wire_q.size()),   32'd4);
      chk("t4_stall_state", 32'(bus.state_o),     32'd2);
      bus.ft_txe_n_i = 1'b0;
      tick(6);
      chk("t4_state_prod", 32'(bus.state_o), 32'd1);
      build_exp(12'h3C7, 12'h000);
      chk_wire("t4_wire");

      // Back-pressure exactly on START and on STOP
      do_reset();
      bus.adc_i = 12'hF01; bus.ft_txe_n_i = 1'b1;
      wire_q.delete();
      tick(8);
      tick(3);
      chk("t5_start_hold_data",  32'(bus.ft_data_o), 32'h5A);
      chk("t5_start_hold_wr_n",  32'(bus.ft_wr_n_o), 32'd1);
      bus.ft_txe_n_i = 1'b0;
      tick(9);
      bus.ft_txe_n_i = 1'b1;
      tick(3);
      chk("t5_stop_hold_state", 32'(bus.state_o),   32'd2);
      chk("t5_stop_hold_data",  32'(bus.ft_data_o), 32'hA5);
      bus.ft_txe_n_i = 1'b0;
      tick(1);
      chk("t5_state_prod", 32'(bus.state_o), 32'd1);
      build_exp(12'hF01, 12'h000);
      chk_wire("t5_wire");

      // Reset pulsed mid-drain aborts without STOP; next burst starts fresh
      do_reset();
      bus.adc_i = 12'h055; bus.ft_txe_n_i = 1'b0;
      wire_q.delete();
      tick(8);
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("t6_state", 32'(bus.state_o),   32'd1);
      chk("t6_empty", 32'(bus.empty_o),   32'd1);
      chk("t6_wr_n",  32'(bus.ft_wr_n_o), 32'd1);
      n_a5 = 0;
      foreach (wire_q[i]) if (wire_q[i] == 8'hA5) n_a5++;
      chk("t6_no_stop", 32'(n_a5), 32'd0);
      rst = 1'b0;
      wire_q.delete();
      tick(18);
      build_exp(12'h055, 12'h000);
      chk_wire("t6_wire");

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
